// File: rtl/cnt_chk_pkg.sv
// Shared types, default widths and the reference next-count rule for the
// up/down counter checker.
package cnt_chk_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } chk_state_t;

  // Computed at 32 bits; callers truncate, which gives the mod 2^WIDTH wrap.
  function automatic logic [31:0] cnt_next(input logic [31:0] count,
                                           input logic        load_en,
                                           input logic [31:0] load,
                                           input logic        down);
    if (load_en) begin
      return load;
    end else if (down) begin
      return count - 32'd1;
    end else begin
      return count + 32'd1;
    end
  endfunction

endpackage

// File: rtl/sat_ctr.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, clears on reset only.
module sat_ctr
  import cnt_chk_pkg::*;
#(
  parameter int unsigned W = STAT_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc && (value_q != {W{1'b1}})) begin
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/counter_ud_checker.sv
// Shadows an external up/down counter, predicting each count and wrap and flagging
// divergence with a one-cycle mismatch pulse plus saturating error/wrap statistics.
module counter_ud_checker
  import cnt_chk_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W,
  parameter int unsigned CW    = STAT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             chk_en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load,
  input  logic             down,
  input  logic [WIDTH-1:0] count,
  input  logic             rollover,
  output logic [WIDTH-1:0] exp_count,
  output logic             mismatch,
  output logic [CW-1:0]    err_cnt,
  output logic [CW-1:0]    roll_cnt,
  output logic [1:0]       state
);

  chk_state_t       state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             mismatch_q, mismatch_d;
  logic             exp_roll;
  logic             roll_inc;

  assign exp_roll = down ? (count == '0) : (count == {WIDTH{1'b1}});

  // Prediction is rebuilt from the observed count so a single bad step cannot cascade.
  assign exp_d = WIDTH'(cnt_next(32'(count), load_en, 32'(load), down));

  always_comb begin
    state_d = state_q;
    if (!chk_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = SYNC;
        SYNC:    state_d = CHECK;
        CHECK:   state_d = CHECK;
        default: state_d = IDLE;
      endcase
    end
  end

  // Dropping chk_en suppresses the comparison taken on the same edge.
  assign mismatch_d = chk_en && (state_q == CHECK) &&
                      ((count != exp_q) || (rollover != exp_roll));

  assign roll_inc = (state_q != IDLE) && rollover && !load_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      exp_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
    end
  end

  sat_ctr #(
    .W(CW)
  ) u_err_ctr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (mismatch_q),
    .value(err_cnt)
  );

  sat_ctr #(
    .W(CW)
  ) u_roll_ctr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (roll_inc),
    .value(roll_cnt)
  );

  assign exp_count = exp_q;
  assign mismatch  = mismatch_q;
  assign state     = state_q;

endmodule

// File: doc/counter_ud_checker.md
COUNTER_UD_CHECKER -- requirements
Module: counter_ud_checker

Interface
REQ-001 Parameter: WIDTH, default 4, width of the load and count buses.
REQ-002 Parameter: CW, default 8, width of the err_cnt and roll_cnt statistics counters.
REQ-003 clk  input  1  single clock; every register is updated on posedge clk.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 chk_en  input  1  enables checking; low means idle and resync.
REQ-006 load_en  input  1  observed counter load strobe.
REQ-007 load  input  WIDTH  observed counter load value.
REQ-008 down  input  1  observed direction: 1 = count down, 0 = count up.
REQ-009 count  input  WIDTH  observed counter value.
REQ-010 rollover  input  1  observed counter wrap indicator.
REQ-011 exp_count  output  WIDTH  predicted count for the current cycle.
REQ-012 mismatch  output  1  one-cycle pulse per detected error.
REQ-013 err_cnt  output  CW  saturating count of mismatches.
REQ-014 roll_cnt  output  CW  saturating count of observed wrap events.
REQ-015 state  output  2  current checker state: IDLE=0, SYNC=1, CHECK=2.

Function
REQ-016 Counter rule, as the checked counter implements it: load_en=1 gives next = load; otherwise down=0 gives next = count+1 mod 2^WIDTH, and down=1 gives next = count-1 mod 2^WIDTH.
REQ-017 Load takes priority over counting; direction is ignored while load_en=1.
REQ-018 Expected rollover is combinational: exp_roll = (!down && count==2^WIDTH-1) || (down && count==0), evaluated from the current-cycle count and down.
REQ-019 State machine transitions:
- IDLE -> SYNC when chk_en=1.
- SYNC -> CHECK unconditionally after one cycle.
- Any state -> IDLE when chk_en=0.
REQ-020 In IDLE and SYNC, every posedge loads exp_count with the REQ-016 next value computed from the sampled count, load_en, load and down.
REQ-021 In CHECK, every posedge does two things:
- Registers mismatch <= (count != exp_count) || (rollover != exp_roll).
- Loads exp_count with the REQ-016 next value from the sampled count, load_en, load and down.
REQ-022 Because exp_count is rebuilt from the observed count, one faulty step produces exactly one mismatch pulse and no cascade.
REQ-023 mismatch is registered: it is asserted in the cycle after the edge that sampled the error, for exactly one cycle per error, and it is 0 outside CHECK.
REQ-024 err_cnt increments on each mismatch pulse and saturates at 2^CW-1 with no wrap.
REQ-025 roll_cnt increments at each posedge where all of these hold: state != IDLE, rollover=1, load_en=0. It saturates at 2^CW-1.
REQ-026 Counter clearing:
- err_cnt and roll_cnt clear only on reset.
- Dropping chk_en retains both counter values.
REQ-027 A rollover sampled together with load_en=1 is not counted in roll_cnt, but it is still compared against exp_roll.
REQ-028 Taking chk_en low mid-CHECK forces IDLE at the next posedge, and the mismatch computed at that edge is suppressed.

Reset
REQ-029 When rstn=0, asynchronously: state=IDLE, exp_count=0, mismatch=0, err_cnt=0, roll_cnt=0.
REQ-030 The first posedge after rstn rises performs normal IDLE behaviour; no extra dead cycle is inserted.
REQ-031 Asserting reset mid-CHECK clears all outputs immediately, with no pending mismatch pulse after release.

Structure
REQ-032 Package cnt_chk_pkg holds:
- the state enum type chk_state_t with values IDLE, SYNC, CHECK;
- the localparam defaults CNT_W=4 and STAT_W=8;
- a pure function cnt_next(count, load_en, load, down) implementing REQ-016.
REQ-033 A single sub-module sat_ctr (parameter W; ports clk, rstn, inc, value) is instantiated twice, once for err_cnt and once for roll_cnt.
REQ-034 The block is synthesizable, with no behavioural-only constructs.

Verification
REQ-035 WIDTH=4, chk_en=1, load_en=0, down=0, correct counter counting 0->15->0 -> mismatch stays 0; the edge sampling count=15 with rollover=1 gives roll_cnt=1.
REQ-036 Load 0xA with down=1, then two correct steps (count 0xA, 0x9, 0x8) -> exp_count tracks 0xB?->0xA->0x9->0x8 with zero mismatches; load overrides direction.
REQ-037 In CHECK, force count=0x5 where exp_count=0x4 for one cycle, then resume correct counting -> exactly one mismatch pulse one cycle later; err_cnt=1.
REQ-038 count=0, down=1, but rollover=0 -> mismatch pulse on the rollover term alone; err_cnt increments.
REQ-039 CW=2, inject 5 errors -> err_cnt reaches 3 and holds 3.
REQ-040 Two abort cases:
- rstn pulled low mid-CHECK with an error pending -> all outputs 0 immediately, no pulse after release.
- chk_en dropped mid-CHECK -> state=IDLE next edge; err_cnt and roll_cnt retained.
